// File: rtl/tdm_frame_sender4.sv
// Four-channel TDM frame sender: one byte buffer per channel, served round-robin
// as UART-style frames (start, 8 data bits LSB first, stop) on oC with a channel select.
module tdm_frame_sender4 (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic [1:0] iCh,
  input  logic       iValid,
  output logic       oReady,
  output logic       oC,
  output logic       oS1,
  output logic       oS0,
  output logic       oBusy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] buf_q [4];
  logic [7:0] buf_d [4];
  logic [3:0] pend_q, pend_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       oc_q, oc_d;
  logic       busy_q, busy_d;

  logic       wr_en;
  logic       pick_vld;
  logic [1:0] pick_ch;
  logic [1:0] idx;

  // Handshake: a byte transfers on a rising edge where iValid and oReady are both 1;
  // oReady depends only on pending[iCh], never on iValid.
  assign oReady    = ~pend_q[iCh];
  assign wr_en     = iValid & oReady;

  assign oC        = oc_q;
  assign oS1       = sel_q[1];
  assign oS0       = sel_q[0];
  assign oBusy     = busy_q;
  assign dbg_state = state_q;

  // Round-robin pick: walk downward so the channel right after last_served wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = last_q;
    idx      = last_q;
    for (int i = 4; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (pend_q[idx]) begin
        pick_vld = 1'b1;
        pick_ch  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    last_d  = last_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    oc_d    = oc_q;
    busy_d  = busy_q;

    if (wr_en) begin
      buf_d[iCh]  = iData;
      pend_d[iCh] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        oc_d   = 1'b1;
        busy_d = 1'b0;
        // The chosen channel is pending, so it cannot be written on this same edge.
        if (pick_vld) begin
          state_d         = START;
          shift_d         = buf_q[pick_ch];
          pend_d[pick_ch] = 1'b0;
          sel_d           = pick_ch;
          last_d          = pick_ch;
          oc_d            = 1'b0;
          busy_d          = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        oc_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = 3'd0;
      end
      DATA: begin
        if (cnt_q == 3'd7) begin
          state_d = STOP;
          oc_d    = 1'b1;
          cnt_d   = 3'd0;
        end else begin
          oc_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      STOP: begin
        state_d = IDLE;
        oc_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    buf_q <= buf_d;
    if (iRst) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      oc_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      oc_q    <= oc_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_tdm_frame_sender4.sv
// Directed bench for tdm_frame_sender4: a negedge monitor decodes frames into a
// queue; the main process drives writes and compares against hand-computed frames.
module tb_tdm_frame_sender4;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iData;
  logic [1:0] iCh;
  logic       iValid;
  logic       oReady;
  logic       oC;
  logic       oS1;
  logic       oS0;
  logic       oBusy;
  logic [1:0] dbg_state;

  tdm_frame_sender4 dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iData     (iData),
    .iCh       (iCh),
    .iValid    (iValid),
    .oReady    (oReady),
    .oC        (oC),
    .oS1       (oS1),
    .oS0       (oS0),
    .oBusy     (oBusy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame monitor ----------------
  // Each completed frame is pushed as {channel, byte}; start cycles go to start_q.
  int         cyc         = 0;
  int         mon_n       = -1;
  int         frames_done = 0;
  logic [1:0] mon_sel;
  logic [7:0] mon_byte;
  logic [9:0] got_q [$];
  int         start_q [$];

  always @(negedge iClk) begin
    cyc++;
    if (mon_n < 0) begin
      if (oBusy === 1'b1) begin
        mon_n   = 0;
        mon_sel = {oS1, oS0};
        start_q.push_back(cyc);
        check("start_bit", 32'(oC), 32'd0);
      end
    end else if (oBusy !== 1'b1) begin
      mon_n = -1;
      if (start_q.size() > 0) void'(start_q.pop_back());
    end else begin
      mon_n++;
      check("sel_stable", 32'({oS1, oS0}), 32'(mon_sel));
      if (mon_n <= 8) begin
        mon_byte[mon_n-1] = oC;
      end else begin
        check("stop_bit", 32'(oC), 32'd1);
        got_q.push_back({mon_sel, mon_byte});
        frames_done++;
        mon_n = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge iClk);
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic write_ch(input logic [1:0] ch, input logic [7:0] d);
    iCh    = ch;
    iData  = d;
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge iClk);
    check("frame_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic expect_frame(input logic [1:0] ch, input logic [7:0] d);
    logic [9:0] exp_v;
    exp_v = {ch, d};
    if (got_q.size() > 0) check("frame_data", 32'(got_q.pop_front()), 32'(exp_v));
    else check("frame_missing", 32'd0, 32'(exp_v));
  endtask

  task automatic check_spacing();
    for (int i = 1; i < start_q.size(); i++)
      check("start_spacing", 32'(start_q[i] - start_q[i-1]), 32'd11);
    start_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int snap;

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    iCh    = 2'd0;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;

    // Reset state
    check("rst_oc",    32'(oC),        32'd1);
    check("rst_busy",  32'(oBusy),     32'd0);
    check("rst_sel",   32'({oS1, oS0}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    for (int c = 0; c < 4; c++) begin
      iCh = 2'(c);
      #1;
      check("rst_ready", 32'(oReady), 32'd1);
    end

    // Single frame ch2 = A5: oC 0,1,0,1,0,0,1,0,1,1 from the edge after acceptance
    write_ch(2'd2, 8'hA5);
    check("ready_after_write", 32'(oReady), 32'd0);
    @(negedge iClk);
    check("latency_oc",   32'(oC),         32'd0);
    check("latency_busy", 32'(oBusy),      32'd1);
    check("latency_sel",  32'({oS1, oS0}), 32'd2);
    wait_frames(1);
    expect_frame(2'd2, 8'hA5);
    repeat (2) @(negedge iClk);
    check("idle_oc",   32'(oC),    32'd1);
    check("idle_busy", 32'(oBusy), 32'd0);
    start_q.delete();

    // Rewrite ch1 during its own DATA phase: both bytes go out intact
    write_ch(2'd1, 8'h0F);
    repeat (3) @(negedge iClk);
    iCh = 2'd1;
    #1;
    check("ready_own_frame", 32'(oReady), 32'd1);
    write_ch(2'd1, 8'hF0);
    wait_frames(2);
    expect_frame(2'd1, 8'h0F);
    expect_frame(2'd1, 8'hF0);
    check_spacing();

    // Round-robin: after reset ch3 goes first; then ch3, ch0, ch1 queued during
    // that frame come out as 0, 1, 3 because the search restarts after ch3.
    do_reset();
    start_q.delete();
    write_ch(2'd3, 8'h3C);
    repeat (2) @(negedge iClk);
    write_ch(2'd3, 8'hC3);
    write_ch(2'd0, 8'h11);
    write_ch(2'd1, 8'h22);
    wait_frames(4);
    expect_frame(2'd3, 8'h3C);
    expect_frame(2'd0, 8'h11);
    expect_frame(2'd1, 8'h22);
    expect_frame(2'd3, 8'hC3);
    check_spacing();

    // Second write to a pending channel is refused and never sent
    write_ch(2'd0, 8'h5A);
    iCh = 2'd0;
    #1;
    check("ready_blocked", 32'(oReady), 32'd0);
    write_ch(2'd0, 8'h99);
    wait_frames(1);
    expect_frame(2'd0, 8'h5A);
    repeat (25) @(negedge iClk);
    check("no_extra_frame", 32'(got_q.size()), 32'd0);
    check("blocked_idle",   32'(oBusy),        32'd0);
    start_q.delete();

    // Reset at DATA bit 4 aborts the frame and drops queued ch1; iValid ignored in reset
    do_reset();
    snap = frames_done;
    write_ch(2'd2, 8'hFF);
    write_ch(2'd1, 8'h00);
    repeat (5) @(negedge iClk);
    check("abort_in_data", 32'(dbg_state), 32'd2);
    iRst   = 1'b1;
    iValid = 1'b1;
    iCh    = 2'd3;
    iData  = 8'h77;
    @(negedge iClk);
    iRst   = 1'b0;
    iValid = 1'b0;
    check("abort_oc",   32'(oC),         32'd1);
    check("abort_busy", 32'(oBusy),      32'd0);
    check("abort_sel",  32'({oS1, oS0}), 32'd0);
    #1;
    check("valid_in_reset", 32'(oReady), 32'd1);
    iCh = 2'd1;
    #1;
    check("queue_dropped", 32'(oReady), 32'd1);
    repeat (30) @(negedge iClk);
    check("no_frames_after_reset", 32'(frames_done - snap), 32'd0);
    check("abort_stays_idle",      32'(oBusy),              32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
